clockworks: RTL and testbench

//  Gearbox and reset generator between the board clock/reset button and the SoC core.
//  - Divides the board clock CLK by a power of two to produce the core clock clk.

---
 rtl/clockworks.sv | 58 +++++
 tb/tb_clockworks.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/clockworks.sv
// rtl/clockworks.sv - board clock divider and stretched core reset generator
// Core clock is a power-of-two division of CLK; core reset releases after a counted stretch.
module clockworks #(
   parameter int SLOW     = 0,
   parameter int RST_BITS = 16
) (
   input  logic CLK,
   input  logic RESET,
   output logic clk,
   output logic resetn
);

   generate
      if (SLOW == 0) begin : g_nodiv
         assign clk = CLK;
      end else begin : g_div
         logic [SLOW-1:0] div_cnt_q;
         logic [SLOW-1:0] div_cnt_d;

         always_comb begin
            div_cnt_d = div_cnt_q + SLOW'(1);
         end

         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               div_cnt_q <= '0;
            end else begin
               div_cnt_q <= div_cnt_d;
            end
         end

         // Taking the MSB of a register keeps the core clock glitch-free.
         assign clk = div_cnt_q[SLOW-1];
      end
   endgenerate

   logic [RST_BITS-1:0] rst_cnt_q;
   logic [RST_BITS-1:0] rst_cnt_d;

   // Saturating at all-ones makes resetn rise exactly once per release.
   always_comb begin
      rst_cnt_d = rst_cnt_q;
      if (!(&rst_cnt_q)) begin
         rst_cnt_d = rst_cnt_q + RST_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         rst_cnt_q <= '0;
      end else begin
         rst_cnt_q <= rst_cnt_d;
      end
   end

   assign resetn = &rst_cnt_q;

endmodule

// File: tb/tb_clockworks.sv
// tb/tb_clockworks.sv - self-checking bench for clockworks (divided and undivided configurations)
module tb_clockworks;

   logic CLK;
   logic RESET;
   logic clk_a;
   logic resetn_a;
   logic clk_b;
   logic resetn_b;

   int   errors;
   int   checks;
   int   n;

   clockworks #(.SLOW(2), .RST_BITS(3)) dut_a (
      .CLK    (CLK),
      .RESET  (RESET),
      .clk    (clk_a),
      .resetn (resetn_a)
   );

   clockworks #(.SLOW(0), .RST_BITS(2)) dut_b (
      .CLK    (CLK),
      .RESET  (RESET),
      .clk    (clk_b),
      .resetn (resetn_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // n = CLK rising edges since RESET last went high (0 while held low)
   function automatic logic m_clk_a(input int k);
      return (k % 4) >= 2;
   endfunction

   function automatic logic m_rstn_a(input int k);
      int rises;
      rises = (k + 2) / 4;
      return rises >= 7;
   endfunction

   function automatic logic m_rstn_b(input int k);
      return k >= 3;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (n=%0d t=%0t)", name, act, exp, n, $time);
      end
   endtask

   task automatic check_all(input logic clk_level);
      chk("clk_a", clk_a, m_clk_a(n));
      chk("resetn_a", resetn_a, m_rstn_a(n));
      chk("clk_b", clk_b, clk_level);
      chk("resetn_b", resetn_b, m_rstn_b(n));
   endtask

   task automatic cyc();
      @(posedge CLK);
      if (RESET) n++;
      #1;
      check_all(1'b1);
      @(negedge CLK);
      #1;
      check_all(1'b0);
   endtask

   task automatic pulse_reset(input int cycles);
      RESET = 1'b0;
      n = 0;
      #1;
      check_all(1'b0);
      repeat (cycles) cyc();
      RESET = 1'b1;
   endtask

   typedef struct {
      int   n;
      logic exp_clk_a;
      logic exp_rstn_a;
      logic exp_rstn_b;
   } vec_t;

   vec_t vecs[12];

   initial begin
      errors = 0;
      checks = 0;
      n = 0;

      vecs[0]  = '{1,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2,  1'b1, 1'b0, 1'b0};
      vecs[2]  = '{3,  1'b1, 1'b0, 1'b1};
      vecs[3]  = '{4,  1'b0, 1'b0, 1'b1};
      vecs[4]  = '{6,  1'b1, 1'b0, 1'b1};
      vecs[5]  = '{10, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{24, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{25, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{26, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{27, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{28, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{60, 1'b0, 1'b1, 1'b1};

      // held in reset
      RESET = 1'b0;
      repeat (10) cyc();

      // release (away from the CLK rising edge) and walk the table
      RESET = 1'b1;
      for (int i = 0; i < 12; i++) begin
         while (n < vecs[i].n) cyc();
         chk("tbl_clk_a", clk_a, vecs[i].exp_clk_a);
         chk("tbl_resetn_a", resetn_a, vecs[i].exp_rstn_a);
         chk("tbl_resetn_b", resetn_b, vecs[i].exp_rstn_b);
      end

      // one-cycle reset pulse while running: immediate clear, full stretch again
      pulse_reset(1);
      chk("mid_run_clk_a", clk_a, 1'b0);
      chk("mid_run_resetn_a", resetn_a, 1'b0);
      repeat (30) cyc();
      chk("restretch_resetn_a", resetn_a, 1'b1);

      // reset pulse after 4 core clock edges of a stretch
      pulse_reset(2);
      while (n < 14) cyc();
      chk("pre_pulse_resetn_a", resetn_a, 1'b0);
      pulse_reset(1);
      repeat (25) cyc();
      chk("pulse_25_resetn_a", resetn_a, 1'b0);
      cyc();
      chk("pulse_26_resetn_a", resetn_a, 1'b1);

      // random reset pulse lengths and run lengths
      for (int r = 0; r < 25; r++) begin
         pulse_reset(int'($urandom_range(1, 4)));
         repeat ($urandom_range(1, 40)) cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
